// File: rtl/ram_arbiter.sv
// ram_arbiter
// -----------------------------------------------------------------------------
// Shares one single-port data RAM between two requesters: m0 (core load/store
// path) and m1 (debug / firmware loader). Only one access is in flight at a
// time. Requests are arbitrated round-robin. The arbiter counts out the fixed
// RAM read latency and then returns the read data to the requester that owned
// the read.
//
// Optional build macro: RAM_ARB_M0_PRIORITY_EN
//   Defined   : m0 wins every conflict. m1 is protected from starvation by a
//               wait counter. After MAX_WAIT lost conflicts, m1 wins the next one.
//   Undefined : pure round-robin. MAX_WAIT only takes part in the parameter
//               legality check.
//
// Ports
//   clk, a_reset                     clock (rising edge), async active-high reset
//   mX_req/we/addr/wdata             request from requester X (held until mX_gnt)
//   mX_gnt                           request accepted this cycle
//   mX_rvalid/mX_rdata               read response; rvalid is a 1-cycle pulse and
//                                    rdata holds its value after the pulse
//   ram_en/we/address/wdata          access strobe and payload to the RAM
//   ram_rdata                        RAM read data, valid READ_LATENCY cycles
//                                    after a read strobe
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int RAM_WIDTH    = 31,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic                  clk,
  input  logic                  a_reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [RAM_WIDTH-1:0]  m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [RAM_WIDTH-1:0]  m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_WIDTH-1:0]  ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // Catch an illegal configuration at elaboration. The latency counter below
  // is two bits wide, so it supports read latencies of 1 to 4 cycles.
  if (READ_LATENCY < 1 || READ_LATENCY > 4 || MAX_WAIT < 1) begin : gBadParams
    $error("ram_arbiter: READ_LATENCY must be 1..4 and MAX_WAIT at least 1");
  end

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      latCnt_q, latCnt_d;
  logic                  owner_q, owner_d;
  logic                  m0Rvalid_q, m0Rvalid_d;
  logic                  m1Rvalid_q, m1Rvalid_d;
  logic [DATA_WIDTH-1:0] m0Rdata_q, m0Rdata_d;
  logic [DATA_WIDTH-1:0] m1Rdata_q, m1Rdata_d;

  logic grantEn;
  logic winM1;
  logic conflictWinM1;

`ifdef RAM_ARB_M0_PRIORITY_EN
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;

  // When both requesters conflict, m1 wins only after it has lost MAX_WAIT times.
  assign conflictWinM1 = (waitCnt_q == WAIT_MAX);
`else
  // rrLast_q holds the most recent winner (1 = m1). When both requesters
  // conflict, the other requester wins.
  logic rrLast_q, rrLast_d;

  assign conflictWinM1 = ~rrLast_q;
`endif

  // The grant is chosen combinationally in IDLE. The winner's payload goes to
  // the RAM in the same cycle. When nothing is granted, the address and data
  // muxes default to m0 so that the idle outputs are deterministic.
  assign winM1       = m1_req & (~m0_req | conflictWinM1);
  assign grantEn     = (state_q == ST_IDLE) & (m0_req | m1_req) & ~a_reset;
  assign m0_gnt      = grantEn & ~winM1;
  assign m1_gnt      = grantEn & winM1;
  assign ram_en      = grantEn;
  assign ram_we      = grantEn & (winM1 ? m1_we : m0_we);
  assign ram_address = m1_gnt ? m1_addr  : m0_addr;
  assign ram_wdata   = m1_gnt ? m1_wdata : m0_wdata;

  assign m0_rvalid = m0Rvalid_q;
  assign m1_rvalid = m1Rvalid_q;
  assign m0_rdata  = m0Rdata_q;
  assign m1_rdata  = m1Rdata_q;

  // Next-state logic for the access sequencer.
  // A granted write completes in its grant cycle, so the FSM stays in IDLE.
  // A granted read moves to READ and counts down. When the count reaches 0,
  // ram_rdata is valid: it is captured for the owner and the FSM returns to
  // IDLE. IDLE can then grant again in the same cycle that the response pulse
  // is visible.
  always_comb begin
    state_d    = state_q;
    latCnt_d   = latCnt_q;
    owner_d    = owner_q;
    m0Rvalid_d = 1'b0;
    m1Rvalid_d = 1'b0;
    m0Rdata_d  = m0Rdata_q;
    m1Rdata_d  = m1Rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grantEn && !ram_we) begin
          state_d  = ST_READ;
          latCnt_d = CNT_LOAD;
          owner_d  = winM1;
        end
      end
      ST_READ: begin
        if (latCnt_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q) begin
            m1Rvalid_d = 1'b1;
            m1Rdata_d  = ram_rdata;
          end else begin
            m0Rvalid_d = 1'b1;
            m0Rdata_d  = ram_rdata;
          end
        end else begin
          latCnt_d = latCnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef RAM_ARB_M0_PRIORITY_EN
  // Starvation counter. It counts the IDLE cycles in which m1 was asking but
  // m0 was granted. It clears as soon as m1 is served or stops asking.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!m1_req || m1_gnt) begin
      waitCnt_d = '0;
    end else if (m0_gnt && waitCnt_q != WAIT_MAX) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // Register for the starvation counter.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end
`else
  // The round-robin pointer follows every grant.
  always_comb begin
    rrLast_d = rrLast_q;
    if (grantEn) begin
      rrLast_d = winM1;
    end
  end

  // Register for the round-robin pointer. Reset favours m0 first.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      rrLast_q <= 1'b1;
    end else begin
      rrLast_q <= rrLast_d;
    end
  end
`endif

  // Sequencer and response registers. A reset during a read aborts the read
  // silently: the state returns to IDLE and no rvalid is ever issued.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q    <= ST_IDLE;
      latCnt_q   <= '0;
      owner_q    <= 1'b0;
      m0Rvalid_q <= 1'b0;
      m1Rvalid_q <= 1'b0;
      m0Rdata_q  <= '0;
      m1Rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      latCnt_q   <= latCnt_d;
      owner_q    <= owner_d;
      m0Rvalid_q <= m0Rvalid_d;
      m1Rvalid_q <= m1Rvalid_d;
      m0Rdata_q  <= m0Rdata_d;
      m1Rdata_q  <= m1Rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// -----------------------------------------------------------------------------
// Scoreboard bench for ram_arbiter.
//
// The predictor process samples the requests every cycle and works out which
// requester should own the RAM. It does this from the arbitration rules: the
// last winner, the cycle at which the port frees up, and a shadow copy of the
// memory. It checks the grant and RAM-side outputs, and it queues the read
// response that the DUT should return later.
//
// The monitor process pops the queue and checks the rvalid / rdata outputs of
// both requesters.
//
// A small behavioural RAM model with READ_LATENCY cycles of latency sits on
// the RAM side of the DUT.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int AW   = 31;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int MAXW = 4;
  localparam int MEMN = 64;

  logic          clk = 1'b0;
  logic          a_reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int cyc          = 0;
  int compareCount = 0;
  int failCount    = 0;

  typedef struct {
    logic          who;
    logic [DW-1:0] data;
    int            due;
  } resp_t;

  resp_t respQ[$];

  ram_arbiter #(
    .RAM_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .a_reset(a_reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Cycle number used to time-stamp expected read responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Initial content of every RAM word that has not been written yet.
  function automatic logic [DW-1:0] fillValue(input int a);
    logic [DW-1:0] v;
    v = 32'h5A5A_0000 + DW'(a);
    if (a == 16) v = 32'hDEAD_BEEF;
    return v;
  endfunction

  // Behavioural RAM. It is loaded on the first edge, while the DUT is still in
  // reset. Read data moves through LAT pipeline stages. Stages that are not
  // read carry a poison value, so a mistimed capture is visible.
  logic [DW-1:0] devMem [MEMN];
  logic [DW-1:0] pipe   [LAT];
  logic          ramLoaded = 1'b0;

  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < MEMN; i++) devMem[i] <= fillValue(i);
      ramLoaded <= 1'b1;
    end else if (ram_en && ram_we) begin
      devMem[ram_address[5:0]] <= ram_wdata;
    end
    pipe[0] <= (ram_en && !ram_we) ? devMem[ram_address[5:0]] : 32'hBAD0_BAD0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign ram_rdata = pipe[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compareCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic w0, input logic [5:0] a0, input logic [DW-1:0] d0,
                               input logic r1, input logic w1, input logic [5:0] a1, input logic [DW-1:0] d1);
    a_reset  = rst;
    m0_req   = r0;  m0_we = w0;  m0_addr = AW'(a0);  m0_wdata = d0;
    m1_req   = r1;  m1_we = w1;  m1_addr = AW'(a1);  m1_wdata = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, '0, 1'b0, 1'b0, 6'h0, '0);
  endtask

  // Predictor: applies the arbitration rules to the current cycle's requests.
  initial begin : predictor
    logic [DW-1:0] expMem [MEMN];
    logic          lastWin;
    int            freeAt;
    int            waitM1;
    logic          anyGnt, winM1, expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    for (int i = 0; i < MEMN; i++) expMem[i] = fillValue(i);
    lastWin = 1'b1;
    freeAt  = 0;
    waitM1  = 0;
    forever begin
      @(negedge clk);
      if (a_reset) begin
        respQ.delete();
        lastWin = 1'b1;
        freeAt  = 0;
        waitM1  = 0;
        checkOutput("m0_gnt_in_reset", 64'(m0_gnt), 64'd0);
        checkOutput("m1_gnt_in_reset", 64'(m1_gnt), 64'd0);
        checkOutput("ram_en_in_reset", 64'(ram_en), 64'd0);
        checkOutput("ram_we_in_reset", 64'(ram_we), 64'd0);
      end else begin
        anyGnt = (cyc >= freeAt) && (m0_req || m1_req);
        winM1  = 1'b0;
        if (anyGnt) begin
          if (m0_req && m1_req) begin
`ifdef RAM_ARB_M0_PRIORITY_EN
            winM1 = (waitM1 >= MAXW);
`else
            winM1 = (lastWin == 1'b0);
`endif
          end else begin
            winM1 = m1_req;
          end
        end
        expWe    = anyGnt && (winM1 ? m1_we : m0_we);
        expAddr  = (anyGnt && winM1) ? m1_addr  : m0_addr;
        expWdata = (anyGnt && winM1) ? m1_wdata : m0_wdata;
        checkOutput("m0_gnt", 64'(m0_gnt), 64'(anyGnt && !winM1));
        checkOutput("m1_gnt", 64'(m1_gnt), 64'(anyGnt && winM1));
        checkOutput("ram_en", 64'(ram_en), 64'(anyGnt));
        checkOutput("ram_we", 64'(ram_we), 64'(expWe));
        checkOutput("ram_address", 64'(ram_address), 64'(expAddr));
        checkOutput("ram_wdata", 64'(ram_wdata), 64'(expWdata));
        if (anyGnt) begin
          lastWin = winM1;
          if (expWe) begin
            expMem[expAddr[5:0]] = expWdata;
          end else begin
            respQ.push_back('{who: winM1, data: expMem[expAddr[5:0]], due: cyc + LAT + 1});
            freeAt = cyc + LAT + 1;
          end
        end
`ifdef RAM_ARB_M0_PRIORITY_EN
        if (!m1_req || (anyGnt && winM1)) waitM1 = 0;
        else if (anyGnt) waitM1++;
`endif
      end
    end
  end

  // Monitor: runs just after the predictor and checks the response side.
  initial begin : monitor
    logic [DW-1:0] expRd0, expRd1;
    logic          exp0, exp1;
    resp_t         item;
    expRd0 = '0;
    expRd1 = '0;
    forever begin
      @(negedge clk);
      #1;
      exp0 = 1'b0;
      exp1 = 1'b0;
      if (a_reset) begin
        expRd0 = '0;
        expRd1 = '0;
      end else if (respQ.size() > 0 && respQ[0].due == cyc) begin
        item = respQ.pop_front();
        if (item.who) begin
          exp1   = 1'b1;
          expRd1 = item.data;
        end else begin
          exp0   = 1'b1;
          expRd0 = item.data;
        end
      end
      checkOutput("m0_rvalid", 64'(m0_rvalid), 64'(exp0));
      checkOutput("m1_rvalid", 64'(m1_rvalid), 64'(exp1));
      checkOutput("m0_rdata", 64'(m0_rdata), 64'(expRd0));
      checkOutput("m1_rdata", 64'(m1_rdata), 64'(expRd1));
    end
  end

  // Stimulus: directed scenarios first, then randomised traffic.
  initial begin : stimulus
    logic          rst, r0, w0, r1, w1;
    logic [5:0]    a0, a1;
    logic [DW-1:0] d0, d1;
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h0, '0, 1'b0, 1'b0, 6'h0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h0, '0, 1'b0, 1'b0, 6'h0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h0, '0, 1'b0, 1'b0, 6'h0, '0);

    // Single m0 read of address 0x10, which holds 0xDEADBEEF.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h10, '0, 1'b0, 1'b0, 6'h0, '0);
    idleCycles(4);

    // Both requesters write continuously; the grants must alternate.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 6'(i), 32'hA, 1'b1, 1'b1, 6'(i + 8), 32'hB);
    idleCycles(2);

    // m1 read, with m0 asking during the read and then read back.
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, '0, 1'b1, 1'b0, 6'h3, '0);
    for (int i = 0; i < LAT + 1; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 6'h9, '0, 1'b0, 1'b0, 6'h0, '0);
    idleCycles(4);

    // Reset one cycle after a read grant, then an m1 read right after release.
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, '0, 1'b1, 1'b0, 6'h2, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h0, '0, 1'b0, 1'b0, 6'h0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, '0, 1'b1, 1'b0, 6'h4, '0);
    idleCycles(4);

    // m1 raises a request for one cycle while the port is busy, then drops it.
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h5, '0, 1'b0, 1'b0, 6'h0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h0, '0, 1'b1, 1'b1, 6'h6, 32'h66);
    idleCycles(4);

    // Long conflicting write burst.
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 6'(i), 32'h100 + DW'(i), 1'b1, 1'b1, 6'(i + 16), 32'h200 + DW'(i));
    idleCycles(3);

    // Random traffic, including occasional resets and requests that are withdrawn.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      r0  = ($urandom_range(0, 99) < 55);
      w0  = $urandom_range(0, 1) == 1;
      a0  = 6'($urandom_range(0, 31));
      d0  = $urandom;
      r1  = ($urandom_range(0, 99) < 55);
      w1  = $urandom_range(0, 1) == 1;
      a1  = 6'($urandom_range(0, 31));
      d1  = $urandom;
      applyStimulus(rst, r0, w0, a0, d0, r1, w1, a1, d1);
    end
    idleCycles(LAT + 6);

    checkOutput("responses_outstanding", 64'(respQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: m0 (core load/store path) and m1 (debug/firmware loader).
- Sits between the requesters and the ram instance.
- Serialises accesses, arbitrates round-robin, sequences the fixed RAM read latency, and returns read data to the granted requester.
- One access in flight at a time.

Parameters:
RAM_WIDTH, 31, address width of RAM and requester address ports
DATA_WIDTH, 32, data width
READ_LATENCY, 1, cycles from ram_en (read) to valid ram_rdata; legal 1..4
MAX_WAIT, 4, starvation bound for m1; used only with the optional feature

Ports:
clk  in  1  clock, rising edge
a_reset  in  1  asynchronous reset, active-high
m0_req  in  1  m0 access request; held with payload stable until m0_gnt
m0_we  in  1  m0 write (1) / read (0)
m0_addr  in  RAM_WIDTH  m0 address
m0_wdata  in  DATA_WIDTH  m0 write data
m0_gnt  out  1  m0 request accepted this cycle
m0_rvalid  out  1  m0 read data valid, 1-cycle pulse
m0_rdata  out  DATA_WIDTH  m0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: as m0, for requester m1
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable, only with ram_en
ram_address  out  RAM_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data

Behaviour:

Reset:
- a_reset high: state IDLE, rr_last=1 (m0 favoured first), latency counter 0, mX_rvalid=0, mX_rdata=0.
- While a_reset is high: gnt, ram_en and ram_we forced 0.

States: IDLE, READ.

IDLE:
- Winner chosen combinationally from m0_req/m1_req.
- If only one requests, it wins. If both request, the one not equal to rr_last wins.
- Winner's gnt=1, ram_en=1, ram_we=winner we; ram_address/ram_wdata muxed from winner, all in the same cycle.
- rr_last <= winner at clock edge.
- Write: stays IDLE. Back-to-back writes accepted every cycle; alternate when both hold req.
- Read: -> READ; counter <= READ_LATENCY-1; owner <= winner.

READ:
- No grants, ram_en=0.
- Counter decrements each cycle. When counter==0, ram_rdata is sampled into owner's rdata register, owner's rvalid is set, state -> IDLE.
- Timing: grant in cycle N; ram_rdata valid in cycle N+READ_LATENCY; mX_rvalid/mX_rdata high in cycle N+READ_LATENCY+1 for exactly one cycle.
- A new grant is allowed in that same cycle (N+READ_LATENCY+1).

Response outputs:
- mX_rdata holds its last value after rvalid drops.
- The non-owner's rvalid stays 0.

Requester rules:
- Dropping req before gnt is allowed (request withdrawn, no side effects).
- Payload is sampled only in the gnt cycle.

Idle outputs: ram_address/ram_wdata = m0 values when no grant (don't-care, but deterministic).

Reset mid-READ: access aborted, no rvalid issued, state IDLE.

Optional Feature:
RAM_ARB_M0_PRIORITY_EN
- Defined: m0 has fixed priority on conflict. A wait counter (clog2(MAX_WAIT+1) bits) increments each IDLE cycle in which m1_req=1 and m1 loses; it clears when m1 is granted or m1_req=0. When counter==MAX_WAIT, m1 wins the next conflict. rr_last is unused.
- Undefined: pure round-robin as above; MAX_WAIT ignored.

Test Plan:
- Reset then single read: m0 read addr 0x10, RAM holds 0xDEADBEEF, READ_LATENCY=2 -> m0_gnt in cycle N, m0_rvalid=1 with m0_rdata=0xDEADBEEF in cycle N+3 only; m1_rvalid stays 0.
- Simultaneous writes: m0 and m1 both write continuously (m0 data 0xA, m1 data 0xB) from reset -> grants alternate m0,m1,m0,m1 one per cycle; RAM sees alternating ram_we pulses.
- Conflict during read: m1 read granted, m0 requests during READ -> m0_gnt=0 until the m1_rvalid cycle, then m0_gnt=1 in that cycle.
- Reset mid-read: a_reset pulsed in cycle N+1 of a READ_LATENCY=3 read -> no rvalid ever; all outputs 0; next m1 request granted immediately after reset release.
- Withdrawn request: m1_req high 1 cycle during READ then low -> no m1 grant, no RAM access.
- With RAM_ARB_M0_PRIORITY_EN, MAX_WAIT=4: m0 and m1 writing continuously -> 4 m0 grants then 1 m1 grant, repeating.
